// File: rtl/spi_pkg.sv
// Shared definitions for the SPI processing unit.
// Holds the buffer-scheduler state encoding, the select-width helper and the
// default buffer count that the SPI PU top also uses.
package spi_pkg;

    // Default number of rotated buffers in the SPI PU.
    localparam int SPI_DEFAULT_NUMBER_OF_BUFFER = 3;

    // Scheduler states: no SPI transfer in progress / transfer in progress.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_state_t;

    // Width of a buffer-select index. A single buffer still needs a 1-bit index.
    function automatic int SPI_SEL_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Chip-select synchronizer and edge detector.
// Brings the asynchronous, active-low SPI chip select into the clk domain
// through two flops and derives transaction edges from a third flop.
// Edges are suppressed until the block is armed. Arming happens the first time
// a real sample of cs (not a reset value) is seen high. This keeps a reset that
// is released in the middle of a transfer from producing a start or a stop.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   cs    - raw chip select, active-low, asynchronous to clk
//   fall  - cs_s went low this clk (transaction begin), armed only
//   rise  - cs_s went high this clk (transaction end), armed only
//   cs_s  - synchronized chip select
module spi_cs_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    output logic fall,
    output logic rise,
    output logic cs_s
);

    logic       meta_reg;
    logic       sync_reg;
    logic       cs_d_reg;
    logic       armed_reg;
    // fill_reg[1] marks that sync_reg holds a genuine sample of the pin
    // rather than its reset value.
    logic [1:0] fill_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg  <= 1'b1;
            sync_reg  <= 1'b1;
            cs_d_reg  <= 1'b1;
            armed_reg <= 1'b0;
            fill_reg  <= 2'b00;
        end else begin
            meta_reg <= cs;
            sync_reg <= meta_reg;
            cs_d_reg <= sync_reg;
            fill_reg <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && sync_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign cs_s = sync_reg;
    assign fall = armed_reg & cs_d_reg & ~sync_reg;
    assign rise = armed_reg & ~cs_d_reg & sync_reg;

endmodule

// File: rtl/spi_buffer_scheduler.sv
// Buffer bank sequencer for the SPI processing unit.
// One buffer belongs to the processor side (pu_sel) and the one before it
// belongs to the SPI side (spi_sel). Both rotate on each compute cycle. A
// rotation that would land mid-transfer is deferred to the transfer end. A
// second cycle during the same transfer is dropped and counted.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   cycle       - start-of-compute-cycle strobe
//   cs          - SPI chip select, active-low, asynchronous
//   pu_sel      - buffer index owned by the processor side
//   spi_sel     - buffer index owned by the SPI side
//   start/stop  - one-clk transaction begin/end pulses
//   swapped     - one-clk pulse the clk after the new selects appear
//   spi_active  - transfer in progress
//   overrun     - sticky flag for a dropped cycle
//   overrun_cnt - saturating count of dropped cycles
module spi_buffer_scheduler
    import spi_pkg::*;
#(
    parameter int NUMBER_OF_BUFFER = SPI_DEFAULT_NUMBER_OF_BUFFER,
    parameter int CNT_WIDTH        = 8,
    localparam int SEL_WIDTH       = SPI_SEL_W(NUMBER_OF_BUFFER)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cycle,
    input  logic                 cs,
    output logic [SEL_WIDTH-1:0] pu_sel,
    output logic [SEL_WIDTH-1:0] spi_sel,
    output logic                 start,
    output logic                 stop,
    output logic                 swapped,
    output logic                 spi_active,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] overrun_cnt
);

    if (NUMBER_OF_BUFFER < 2 || NUMBER_OF_BUFFER > 16) begin : g_bad_number_of_buffer
        $error("spi_buffer_scheduler: NUMBER_OF_BUFFER must be within 2..16");
    end

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUMBER_OF_BUFFER - 1);

    function automatic logic [SEL_WIDTH-1:0] inc_sel(input logic [SEL_WIDTH-1:0] v);
        if (v == LAST_SEL) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    logic fall;
    logic rise;
    logic cs_s;
    // cs_s is kept on the sync block's interface for debug probing only.
    logic cs_s_unused;

    spi_cs_sync u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .fall (fall),
        .rise (rise),
        .cs_s (cs_s)
    );

    assign cs_s_unused = cs_s;

    spi_state_t           state_reg, state_next;
    logic                 pending_reg, pending_next;
    logic [SEL_WIDTH-1:0] pu_sel_reg, spi_sel_reg;
    logic                 start_reg, start_next;
    logic                 stop_reg, stop_next;
    logic                 rotate;
    logic                 drop;
    logic                 rotate_d_reg;
    logic                 swapped_reg;
    logic                 overrun_reg;
    logic [CNT_WIDTH-1:0] overrun_cnt_reg;

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        start_next   = 1'b0;
        stop_next    = 1'b0;
        rotate       = 1'b0;
        drop         = 1'b0;
        case (state_reg)
            IDLE: begin
                // A cycle coinciding with fall still rotates here, so the
                // SPI side sees the new buffer from its first byte.
                rotate = cycle;
                if (fall) begin
                    state_next = XFER;
                    start_next = 1'b1;
                end
            end
            XFER: begin
                if (rise) begin
                    state_next   = IDLE;
                    stop_next    = 1'b1;
                    rotate       = pending_reg | cycle;
                    pending_next = 1'b0;
                end else if (cycle) begin
                    if (pending_reg) begin
                        drop = 1'b1;
                    end else begin
                        pending_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            pending_reg     <= 1'b0;
            pu_sel_reg      <= '0;
            spi_sel_reg     <= LAST_SEL;
            start_reg       <= 1'b0;
            stop_reg        <= 1'b0;
            rotate_d_reg    <= 1'b0;
            swapped_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
            overrun_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            start_reg    <= start_next;
            stop_reg     <= stop_next;
            rotate_d_reg <= rotate;
            swapped_reg  <= rotate_d_reg;
            if (rotate) begin
                pu_sel_reg  <= inc_sel(pu_sel_reg);
                spi_sel_reg <= inc_sel(spi_sel_reg);
            end
            if (drop) begin
                overrun_reg <= 1'b1;
                if (overrun_cnt_reg != {CNT_WIDTH{1'b1}}) begin
                    overrun_cnt_reg <= overrun_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign pu_sel      = pu_sel_reg;
    assign spi_sel     = spi_sel_reg;
    assign start       = start_reg;
    assign stop        = stop_reg;
    assign swapped     = swapped_reg;
    assign spi_active  = (state_reg == XFER);
    assign overrun     = overrun_reg;
    assign overrun_cnt = overrun_cnt_reg;

endmodule

// File: tb/tb_spi_buffer_scheduler.sv
// Directed bench for spi_buffer_scheduler: one instance with three buffers,
// one with two buffers for the simultaneous fall/cycle case.
module tb_spi_buffer_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cycle = 1'b0;
    logic       cs = 1'b1;
    logic [1:0] pu_sel, spi_sel;
    logic       start, stop, swapped, spi_active, overrun;
    logic [7:0] overrun_cnt;

    logic       cycle2 = 1'b0;
    logic       cs2 = 1'b1;
    logic [0:0] pu_sel2, spi_sel2;
    logic       start2, stop2, swapped2, spi_active2, overrun2;
    logic [7:0] overrun_cnt2;

    int total = 0;
    int bad = 0;
    int n_start = 0, n_stop = 0, n_swap = 0, n_both = 0;

    always #5 clk = ~clk;

    spi_buffer_scheduler #(.NUMBER_OF_BUFFER(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cycle(cycle), .cs(cs),
        .pu_sel(pu_sel), .spi_sel(spi_sel), .start(start), .stop(stop),
        .swapped(swapped), .spi_active(spi_active), .overrun(overrun),
        .overrun_cnt(overrun_cnt)
    );

    spi_buffer_scheduler #(.NUMBER_OF_BUFFER(2), .CNT_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .cycle(cycle2), .cs(cs2),
        .pu_sel(pu_sel2), .spi_sel(spi_sel2), .start(start2), .stop(stop2),
        .swapped(swapped2), .spi_active(spi_active2), .overrun(overrun2),
        .overrun_cnt(overrun_cnt2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge,
    // and new inputs are applied at the same point.
    task automatic step();
        @(posedge clk);
        #2;
        if (start) n_start++;
        if (stop) n_stop++;
        if (swapped) n_swap++;
        if (start && stop) n_both++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        n_start = 0; n_stop = 0; n_swap = 0;
    endtask

    int exp_pu[3]  = '{1, 2, 0};
    int exp_spi[3] = '{0, 1, 2};

    initial begin
        // 1: reset state, then three rotations in IDLE
        run(3);
        chk("rst_pu_sel", int'(pu_sel), 0);
        chk("rst_spi_sel", int'(spi_sel), 2);
        chk("rst_flags", int'({start, stop, swapped, spi_active, overrun}), 0);
        chk("rst_cnt", int'(overrun_cnt), 0);
        rst = 1'b0;
        run(5);
        clr();
        for (int k = 0; k < 3; k++) begin
            cycle = 1'b1;
            step();
            cycle = 1'b0;
            chk($sformatf("idle_rot%0d_pu", k), int'(pu_sel), exp_pu[k]);
            chk($sformatf("idle_rot%0d_spi", k), int'(spi_sel), exp_spi[k]);
            chk($sformatf("idle_rot%0d_swp_early", k), int'(swapped), 0);
            step();
            chk($sformatf("idle_rot%0d_swp", k), int'(swapped), 1);
            step();
            chk($sformatf("idle_rot%0d_swp_end", k), int'(swapped), 0);
        end
        chk("idle_swap_count", n_swap, 3);

        // 2: plain 40-clk transfer
        clr();
        cs = 1'b0;
        run(2);
        chk("xfer_start_early", int'(start), 0);
        step();
        chk("xfer_start", int'(start), 1);
        chk("xfer_active", int'(spi_active), 1);
        run(37);
        cs = 1'b1;
        run(2);
        chk("xfer_stop_early", int'(stop), 0);
        step();
        chk("xfer_stop", int'(stop), 1);
        chk("xfer_idle", int'(spi_active), 0);
        chk("xfer_pu_kept", int'(pu_sel), 0);
        chk("xfer_spi_kept", int'(spi_sel), 2);
        chk("xfer_one_start", n_start, 1);
        run(3);

        // 3: cycle mid-transfer deferred to the rise
        cs = 1'b0;
        run(10);
        cycle = 1'b1;
        step();
        cycle = 1'b0;
        chk("defer_pu_hold", int'(pu_sel), 0);
        run(20);
        cs = 1'b1;
        run(2);
        chk("defer_pu_before_rise", int'(pu_sel), 0);
        step();
        chk("defer_stop", int'(stop), 1);
        chk("defer_pu", int'(pu_sel), 1);
        chk("defer_spi", int'(spi_sel), 0);
        chk("defer_no_overrun", int'(overrun), 0);
        step();
        chk("defer_swapped", int'(swapped), 1);
        run(3);

        // 4: two cycles in one transfer, then saturate the counter
        for (int t = 0; t < 300; t++) begin
            cs = 1'b0;
            run(3);
            cycle = 1'b1; step(); cycle = 1'b0; step();
            cycle = 1'b1; step(); cycle = 1'b0;
            cs = 1'b1;
            run(3);
            if (t == 0) begin
                chk("ovr1_pu", int'(pu_sel), 2);
                chk("ovr1_spi", int'(spi_sel), 1);
                chk("ovr1_flag", int'(overrun), 1);
                chk("ovr1_cnt", int'(overrun_cnt), 1);
            end
            run(2);
        end
        chk("ovr_sat_cnt", int'(overrun_cnt), 255);
        chk("ovr_sat_flag", int'(overrun), 1);
        chk("ovr_sat_pu", int'(pu_sel), 1);
        chk("ovr_sat_spi", int'(spi_sel), 0);

        // 5: reset released while cs is held low
        cs = 1'b0;
        run(4);
        chk("midrst_active_before", int'(spi_active), 1);
        rst = 1'b1;
        step();
        chk("midrst_active", int'(spi_active), 0);
        chk("midrst_pu", int'(pu_sel), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_cnt", int'(overrun_cnt), 0);
        step();
        rst = 1'b0;
        clr();
        run(20);
        cs = 1'b1;
        run(6);
        chk("midrst_no_start", n_start, 0);
        chk("midrst_no_stop", n_stop, 0);
        cs = 1'b0;
        run(5);
        chk("midrst_next_start", n_start, 1);
        cs = 1'b1;
        run(5);
        chk("midrst_next_stop", n_stop, 1);

        // 6: N=2, fall and cycle on the same synchronized clk
        chk("n2_pu_init", int'(pu_sel2), 0);
        chk("n2_spi_init", int'(spi_sel2), 1);
        cs2 = 1'b0;
        run(2);
        cycle2 = 1'b1;
        step();
        cycle2 = 1'b0;
        chk("n2_pu", int'(pu_sel2), 1);
        chk("n2_spi", int'(spi_sel2), 0);
        chk("n2_start", int'(start2), 1);
        chk("n2_active", int'(spi_active2), 1);

        chk("start_stop_exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_buffer_scheduler.md
Name: spi_buffer_scheduler

Overview:
Sequences the buffer bank of the SPI processing unit. Assigns one buffer to the processor side and one to the SPI side, and rotates ownership on each compute `cycle`. Detects SPI transaction boundaries on `cs` to produce `start`/`stop` pulses, and defers any rotation that would land mid-transfer. Sits between the NITTA cycle control and the buffer instances inside the SPI PU.

Parameters:
NUMBER_OF_BUFFER, 3, number of rotated buffers; legal range 2..16, elaborate-time error otherwise.
SEL_WIDTH, $clog2(NUMBER_OF_BUFFER), width of buffer-select indices (derived, not overridden).
CNT_WIDTH, 8, width of the saturating overrun counter.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset, asynchronous, active-high.
cycle  in  1  start-of-compute-cycle strobe, one clk wide, synchronous to clk.
cs  in  1  SPI chip select from external master, active-low, asynchronous to clk.
pu_sel  out  SEL_WIDTH  index of the buffer owned by the processor side.
spi_sel  out  SEL_WIDTH  index of the buffer owned by the SPI side.
start  out  1  one-clk pulse at SPI transaction begin.
stop  out  1  one-clk pulse at SPI transaction end.
swapped  out  1  one-clk pulse on the clk after a rotation is committed.
spi_active  out  1  high while state = XFER.
overrun  out  1  sticky: a cycle arrived while a rotation was already pending.
overrun_cnt  out  CNT_WIDTH  count of dropped cycles; saturates at all-ones.

Behaviour:
- Reset values (all outputs, async on rst high):
  - pu_sel=0, spi_sel=NUMBER_OF_BUFFER-1.
  - start, stop, swapped, spi_active, overrun = 0; overrun_cnt = 0.
  - State IDLE; pending=0; armed=0.
  - cs synchronizer flops reset to 1.
- cs synchronization:
  - cs passes through a 2-flop synchronizer to give cs_s; a third flop cs_d gives the edge.
  - fall = cs_d & ~cs_s; rise = ~cs_d & cs_s.
  - Latency from a cs pin edge to start/stop is 3 clk.
- Post-reset arming: armed sets on the first clk where cs_s=1. fall is ignored while armed=0, so a reset released during an active transfer produces no start and no stop.
- State machine:
  - IDLE -> XFER on fall&armed; start=1 that clk.
  - XFER -> IDLE on rise; stop=1 that clk.
  - No other transitions. spi_active is the registered state.
- Rotation (indices increment modulo NUMBER_OF_BUFFER; N-1 wraps to 0):
  - pu_sel and spi_sel both increment, so the invariant spi_sel == (pu_sel-1) mod N always holds.
  - In IDLE with cycle=1: rotate at that edge; new sel values are visible the next clk; swapped=1 the following clk.
  - In XFER with cycle=1 and pending=0: set pending, no rotation.
  - In XFER with rise: if pending=1 or cycle=1, rotate at the same edge that produces stop, and clear pending.
  - In XFER with cycle=1, pending=1 and no rise: the cycle is dropped; overrun<=1; overrun_cnt increments, saturating.
- Simultaneous fall and cycle in IDLE: the rotation commits and the transfer starts at the same edge, so the SPI side sees the new spi_sel from its first byte.
- At most one rotation per clk. start and stop are never high in the same clk.
- overrun clears only on rst.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE=0, XFER=1);
  - the SPI_SEL_W function wrapping $clog2;
  - default NUMBER_OF_BUFFER constant, shared with the SPI PU top.
- One natural sub-module: spi_cs_sync. It holds the 2-flop synchronizer, the edge flop and armed logic, and outputs fall, rise, cs_s.
- The rotation/FSM logic stays in the parent.

Test Plan:
1. Reset with cs=1, pulse cycle three times in IDLE with N=3 -> pu_sel goes 1,2,0 and spi_sel goes 0,1,2; swapped pulses once per cycle, one clk after the sel update.
2. Drive cs low for 40 clk -> start 3 clk after the fall, spi_active high, stop 3 clk after cs returns high; sel unchanged.
3. Pulse cycle 10 clk into a transfer -> no sel change until rise; rotation and stop occur on the same clk; overrun stays 0.
4. Pulse cycle twice during one transfer -> one rotation at rise, overrun=1, overrun_cnt=1. Repeat 300 times -> overrun_cnt saturates at 255.
5. Hold cs low, assert rst mid-transfer, release rst, keep cs low 20 clk, then raise it -> no start and no stop. The next full cs pulse gives normal start/stop.
6. In IDLE, cs fall and cycle in the same synchronized clk with N=2 -> pu_sel toggles to 1, spi_sel to 0, start asserted; invariant holds.
